// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing and captures visible pixels.
// Ports: clk; i_sclr async active-high reset; i_px_clk pixel strobe;
//   i_vga_hsync/i_vga_vsync active-low syncs; i_vga_red/green/blue in.
//   o_px_valid pulse with o_x/o_y/o_red/o_green/o_blue and o_frame_start;
//   o_locked while timing is locked; o_err pulse on loss of lock.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  input  logic       i_vga_hsync,
  input  logic       i_vga_vsync,
  input  logic [3:0] i_vga_red,
  input  logic [3:0] i_vga_green,
  input  logic [3:0] i_vga_blue,
  output logic       o_px_valid,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS1 = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_VIS0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t     state_q, state_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [3:0] smp_red_q, smp_red_d;
  logic [3:0] smp_green_q, smp_green_d;
  logic [3:0] smp_blue_q, smp_blue_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       lines_ok_q, lines_ok_d;
  logic       px_valid_q, px_valid_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [3:0] red_q, red_d;
  logic [3:0] green_q, green_d;
  logic [3:0] blue_q, blue_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;

  logic hfall, vfall;
  logic line_good, frame_good;
  logic in_win;

  always_comb begin
    hfall = hs_q & ~i_vga_hsync;
    vfall = vs_q & ~i_vga_vsync;
    line_good = (hcount_q == H_LAST);
    // the line closing on this strobe belongs to the frame being judged
    frame_good = (vcount_q == V_LAST) && lines_ok_q
               && (line_good || !hfall);
    // window test applies to the pixel sampled on the previous strobe
    in_win = (hcount_q >= H_VIS0) && (hcount_q < H_VIS1)
          && (vcount_q >= V_VIS0) && (vcount_q < V_VIS1);

    state_d       = state_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    smp_red_d     = smp_red_q;
    smp_green_d   = smp_green_q;
    smp_blue_d    = smp_blue_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    lines_ok_d    = lines_ok_q;
    x_d           = x_q;
    y_d           = y_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    px_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    err_d         = 1'b0;

    if (i_px_clk) begin
      hs_d        = i_vga_hsync;
      vs_d        = i_vga_vsync;
      smp_red_d   = i_vga_red;
      smp_green_d = i_vga_green;
      smp_blue_d  = i_vga_blue;

      if (state_q == LOCKED && in_win) begin
        px_valid_d    = 1'b1;
        x_d           = hcount_q - H_VIS0;
        y_d           = vcount_q - V_VIS0;
        red_d         = smp_red_q;
        green_d       = smp_green_q;
        blue_d        = smp_blue_q;
        frame_start_d = (hcount_q == H_VIS0)
                     && (vcount_q == V_VIS0);
      end

      if (hfall) begin
        hcount_d = 10'd0;
      end else if (hcount_q != CNT_MAX) begin
        hcount_d = hcount_q + 10'd1;
      end

      if (vfall) begin
        vcount_d = 10'd0;
      end else if (hfall && vcount_q != CNT_MAX) begin
        vcount_d = vcount_q + 10'd1;
      end

      if (vfall) begin
        lines_ok_d = 1'b1;
      end else if (hfall) begin
        lines_ok_d = lines_ok_q & line_good;
      end

      unique case (state_q)
        SEARCH: begin
          if (vfall) state_d = MEASURE;
        end
        MEASURE: begin
          if (vfall && frame_good) state_d = LOCKED;
        end
        LOCKED: begin
          if ((hfall && !line_good)
              || (vfall && !frame_good)) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      smp_red_q     <= 4'd0;
      smp_green_q   <= 4'd0;
      smp_blue_q    <= 4'd0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      lines_ok_q    <= 1'b0;
      px_valid_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      red_q         <= 4'd0;
      green_q       <= 4'd0;
      blue_q        <= 4'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      smp_red_q     <= smp_red_d;
      smp_green_q   <= smp_green_d;
      smp_blue_q    <= smp_blue_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      lines_ok_q    <= lines_ok_d;
      px_valid_q    <= px_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign o_px_valid    = px_valid_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;
  assign o_frame_start = frame_start_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives generated VGA frames into vga_capture and
// compares every clk against a line/frame level reference model.
module tb_vga_capture;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HOFF = HS + HB;
  localparam int VOFF = VS + VB;

  localparam int SR = 0;
  localparam int MS = 1;
  localparam int LK = 2;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_px_clk = 1'b0;
  logic       i_vga_hsync = 1'b1;
  logic       i_vga_vsync = 1'b1;
  logic [3:0] i_vga_red = 4'd0;
  logic [3:0] i_vga_green = 4'd0;
  logic [3:0] i_vga_blue = 4'd0;
  logic       o_px_valid;
  logic [9:0] o_x, o_y;
  logic [3:0] o_red, o_green, o_blue;
  logic       o_frame_start, o_locked, o_err;

  vga_capture #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .i_vga_hsync(i_vga_hsync), .i_vga_vsync(i_vga_vsync),
    .i_vga_red(i_vga_red), .i_vga_green(i_vga_green),
    .i_vga_blue(i_vga_blue), .o_px_valid(o_px_valid),
    .o_x(o_x), .o_y(o_y), .o_red(o_red), .o_green(o_green),
    .o_blue(o_blue), .o_frame_start(o_frame_start),
    .o_locked(o_locked), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  int m_err = 0;
  int f_base = 0;
  int frame_cnt = 0;
  int m_st = SR;
  int last_len = -1;
  int lines_seen = 0;
  int rst_left = 0;
  int rst_v = 0;
  int rst_h = 0;
  bit lines_ok = 0;
  bit rst_armed = 0;
  bit line_dirty = 0;
  bit pend_v = 0;
  bit pend_fs = 0;
  logic [31:0] pend_data = '0;
  logic        e_v, e_fs, e_err, e_lk;
  logic [31:0] e_data;
  logic        first_fs;
  logic [19:0] first_xy, last_xy;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic stb, input logic hs,
                      input logic vs, input logic [3:0] r,
                      input logic [3:0] g, input logic [3:0] b);
    @(negedge clk);
    i_px_clk = stb;
    i_vga_hsync = hs;
    i_vga_vsync = vs;
    i_vga_red = r;
    i_vga_green = g;
    i_vga_blue = b;
    @(posedge clk);
    #1;
    check("ctl",
      {28'd0, o_px_valid, o_frame_start, o_err, o_locked},
      {28'd0, e_v, e_fs, e_err, e_lk});
    if (e_v || i_sclr)
      check("data", {o_x, o_y, o_red, o_green, o_blue}, e_data);
    if (o_err) n_err++;
    if (o_px_valid) begin
      if (n_valid == f_base) begin
        first_xy = {o_x, o_y};
        first_fs = o_frame_start;
      end
      last_xy = {o_x, o_y};
      n_valid++;
    end
  endtask

  task automatic idle();
    e_v = 0; e_fs = 0; e_err = 0; e_data = '0;
    e_lk = (m_st == LK);
    step(1'b0, i_vga_hsync, i_vga_vsync,
         4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic model_reset();
    m_st = SR;
    last_len = -1;
    lines_ok = 0;
    lines_seen = 0;
    pend_v = 0;
    pend_fs = 0;
  endtask

  // Line start = hsync fall; v==0 additionally = vsync fall.
  task automatic line_start(input int v);
    bit lg, fg;
    lg = (last_len == HT);
    if (v == 0) begin
      fg = lg && lines_ok && (lines_seen == VT);
      if (m_st == SR) m_st = MS;
      else if (m_st == MS) begin
        if (fg) m_st = LK;
      end else if (!fg) begin
        m_st = SR; e_err = 1; m_err++;
      end
      lines_ok = 1;
      lines_seen = 1;
    end else begin
      if (m_st == LK && !lg) begin
        m_st = SR; e_err = 1; m_err++;
      end
      lines_ok = lines_ok && lg;
      lines_seen++;
    end
  endtask

  task automatic pixel(input int h, input int v);
    logic hs, vs;
    logic [3:0] r, g, b;
    bit win;
    repeat ($urandom_range(0, 2)) idle();
    hs = (h >= HS);
    vs = (v >= VS);
    r = 4'(h - HOFF);
    g = 4'(v - VOFF);
    b = 4'($urandom);
    e_err = 0;
    if (rst_left > 0) begin
      e_v = 0; e_fs = 0; e_lk = 0; e_data = '0;
      step(1'b1, hs, vs, r, g, b);
      rst_left--;
      if (rst_left == 0) i_sclr = 1'b0;
      return;
    end
    if (h == 0) line_start(v);
    e_v = pend_v;
    e_fs = pend_fs;
    e_data = pend_data;
    e_lk = (m_st == LK);
    step(1'b1, hs, vs, r, g, b);
    win = (h >= HOFF) && (h < HOFF + HA)
       && (v >= VOFF) && (v < VOFF + VA);
    pend_v = (m_st == LK) && win;
    pend_fs = pend_v && (h == HOFF) && (v == VOFF);
    if (pend_v)
      pend_data = {10'(h - HOFF), 10'(v - VOFF), r, g, b};
  endtask

  task automatic send_line(input int v, input int len);
    line_dirty = 0;
    for (int h = 0; h < len; h++) begin
      if (rst_armed && v == rst_v && h == rst_h) begin
        rst_armed = 0;
        #2;
        i_sclr = 1'b1;
        #1;
        check("arst_ctl",
          {28'd0, o_px_valid, o_frame_start, o_err, o_locked},
          32'd0);
        check("arst_data",
          {o_x, o_y, o_red, o_green, o_blue}, 32'd0);
        model_reset();
        rst_left = 3;
        line_dirty = 1;
      end
      pixel(h, v);
    end
    last_len = line_dirty ? -1 : len;
  endtask

  task automatic send_frame(input int nlines, input int bad_v,
                            input int bad_len);
    f_base = n_valid;
    for (int v = 0; v < nlines; v++)
      send_line(v, (v == bad_v) ? bad_len : HT);
    frame_cnt = n_valid - f_base;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl",
      {28'd0, o_px_valid, o_frame_start, o_err, o_locked}, 32'd0);
    check("rst_data", {o_x, o_y, o_red, o_green, o_blue}, 32'd0);
    @(negedge clk);
    i_sclr = 1'b0;
    model_reset();

    send_frame(VT, -1, HT);
    check("f1_unlocked", {31'd0, o_locked}, 32'd0);
    send_frame(VT, -1, HT);
    send_frame(VT, -1, HT);
    check("f3_count", frame_cnt, HA * VA);
    check("f3_first", {11'd0, first_fs, first_xy},
          {11'd0, 1'b1, 20'd0});
    check("f3_last", {12'd0, last_xy},
          {12'd0, 10'(HA - 1), 10'(VA - 1)});
    check("f3_locked", {31'd0, o_locked}, 32'd1);

    send_frame(VT, $urandom_range(VOFF, VT - 1), HT - 1);
    check("short_line_unlock", {31'd0, o_locked}, 32'd0);
    send_frame(VT, -1, HT);
    check("short_line_gap", frame_cnt, 0);
    send_frame(VT, -1, HT);
    check("short_line_relock", frame_cnt, HA * VA);

    send_frame(VT - 1, -1, HT);
    send_frame(VT, -1, HT);
    check("short_frame_gap", frame_cnt, 0);
    send_frame(VT, -1, HT);
    check("short_frame_meas", frame_cnt, 0);
    send_frame(VT, -1, HT);
    check("short_frame_relock", frame_cnt, HA * VA);

    rst_armed = 1;
    rst_v = VOFF + 1;
    rst_h = HOFF + 2;
    send_frame(VT, -1, HT);
    send_frame(VT, -1, HT);
    check("rst_gap", frame_cnt, 0);
    send_frame(VT, -1, HT);
    check("rst_relock", frame_cnt, HA * VA);

    send_frame(VT, VOFF + 3, HT + 2000);
    check("sat_unlock", {31'd0, o_locked}, 32'd0);
    send_frame(VT, -1, HT);
    send_frame(VT, -1, HT);
    check("sat_relock", frame_cnt, HA * VA);

    repeat (8) begin
      int k;
      int bv;
      k = $urandom_range(0, 4);
      bv = $urandom_range(0, VT - 2);
      case (k)
        0: send_frame(VT, -1, HT);
        1: send_frame(VT, bv, HT - 1);
        2: send_frame(VT, bv, HT + 1 + $urandom_range(0, 3));
        3: send_frame(VT - 1, -1, HT);
        default: send_frame(VT + 1, -1, HT);
      endcase
    end
    send_frame(VT, -1, HT);

    check("err_total", n_err, m_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines; H_TOTAL=800, V_TOTAL=525 derived.
REQ-005 clk  in  1  system clock; one clock; all state on rising edge.
REQ-006 i_sclr  in  1  reset, asynchronous, active-high.
REQ-007 i_px_clk  in  1  pixel-enable strobe, one clk cycle wide per pixel.
REQ-008 i_vga_hsync, i_vga_vsync  in  1 each  sync inputs, active-low, synchronous to clk.
REQ-009 i_vga_red, i_vga_green, i_vga_blue  in  4 each  pixel colour.
REQ-010 o_px_valid  out  1  one-clk pulse per captured visible pixel.
REQ-011 o_x, o_y  out  10 each  coordinates of the captured pixel.
REQ-012 o_red, o_green, o_blue  out  4 each  captured colour.
REQ-013 o_frame_start  out  1  one-clk pulse coincident with o_px_valid for pixel (0,0).
REQ-014 o_locked  out  1  high while the timing FSM is in LOCKED.
REQ-015 o_err  out  1  one-clk pulse on timing violation while LOCKED.

Function
REQ-016 All logic other than output pulses advances only on clk edges with i_px_clk=1; sync and colour inputs are registered on every strobe.
REQ-017 hsync falling edge = previous registered hsync 1, current sample 0; vsync falling edge defined likewise.
REQ-018 hcount (10 bit) is 0 on the hsync-falling-edge pixel, +1 on each subsequent strobe, saturates at 1023.
REQ-019 vcount (10 bit) is 0 on the line where vsync falls, +1 on each hsync falling edge, saturates at 1023; when hsync and vsync fall on the same strobe, both counters go to 0.
REQ-020 Visible window: H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE (144..783), V_SYNC+V_BP <= vcount < V_SYNC+V_BP+V_ACTIVE (35..514).
REQ-021 Line check: at each hsync falling edge, line is good iff previous hcount == H_TOTAL-1.
REQ-022 Frame check: at each vsync falling edge, frame is good iff previous vcount == V_TOTAL-1 and every line since the previous vsync fall was good.
REQ-023 FSM states SEARCH, MEASURE, LOCKED; after reset: SEARCH.
REQ-024 SEARCH -> MEASURE on first vsync falling edge.
REQ-025 MEASURE -> LOCKED on a vsync falling edge closing a good frame; a bad frame stays in MEASURE and restarts the check.
REQ-026 LOCKED -> SEARCH on any bad line (checked at the hsync fall) or bad frame (checked at the vsync fall); o_err pulses for one clk on that transition.
REQ-027 A pixel sampled at strobe n inside the visible window while in LOCKED is presented at the clk edge of strobe n+1: o_x=hcount-144, o_y=vcount-35, colour as sampled, o_px_valid high for that one clk.
REQ-028 o_x, o_y and colour hold between updates; no o_px_valid when not LOCKED or outside the window.
REQ-029 A pixel sampled on the strobe that causes the LOCKED exit is not presented.

Reset
REQ-030 While i_sclr=1: FSM=SEARCH; hcount, vcount, sync registers (reset to 1), o_x, o_y and colour outputs = 0; o_px_valid, o_frame_start, o_locked and o_err = 0.
REQ-031 Reset mid-frame discards all timing history; relock requires a new vsync fall plus one full good frame.

Verification
REQ-032 Reset, then 3 ideal 800x525 frames from a reference generator -> o_locked rises at the 2nd vsync fall; 3rd frame yields exactly 307200 o_px_valid pulses, first with o_x=0, o_y=0 and o_frame_start=1, last with o_x=639, o_y=479.
REQ-033 Locked, one line shortened to 799 pixels -> o_err one pulse at the following hsync fall, o_locked=0, no o_px_valid until relock after one good frame.
REQ-034 Locked, frame of 524 lines -> o_err at the vsync fall, state SEARCH; the next vsync fall moves to MEASURE.
REQ-035 Colour ramp red=x[3:0], green=y[3:0] -> every captured pixel matches its coordinates with 1-strobe latency.
REQ-036 i_sclr asserted mid-line while locked -> all outputs 0 asynchronously; o_locked stays low until two vsync falls after release.
REQ-037 Sync held high for 2000 strobes -> hcount saturates at 1023, no o_px_valid, no o_err.
